// File: rtl/flit_sink_monitor_if.sv
// Valid/ready flit link between a flit source and a flit sink.
// The source drives valid/data and the sink drives ready.
interface flit_sink_monitor_if #(
    parameter int FLIT_W = 60
);
    logic              flit_valid;
    logic [FLIT_W-1:0] flit_data;
    logic              flit_ready;

    modport master (
        output flit_valid,
        output flit_data,
        input  flit_ready
    );

    modport slave (
        input  flit_valid,
        input  flit_data,
        output flit_ready
    );
endinterface

// File: rtl/flit_sink_monitor.sv
// Flit sink: frames packets and counts packets, flits, idles and toggles.
// Optional FLIT_READY_EN: drop ready for STALL_CYCLES after each packet.
module flit_sink_monitor #(
    parameter int FLIT_W       = 60,
    parameter int PAYLOAD      = 20,
    parameter int MAX_GAP      = 16,
    parameter int CNT_W        = 32,
    parameter int STALL_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    flit_sink_monitor_if.slave   link,
    input  logic                 clear,
    output logic                 pkt_done,
    output logic                 pkt_err,
    output logic [CNT_W-1:0]     pkt_count,
    output logic [CNT_W-1:0]     flit_count,
    output logic [CNT_W-1:0]     idle_count,
    output logic [CNT_W-1:0]     err_count,
    output logic [CNT_W-1:0]     toggle_count
);

    localparam int PW = $clog2(FLIT_W + 1);
    localparam int IW = $clog2(PAYLOAD + 1);
    localparam int GW = $clog2(MAX_GAP + 1);

    localparam logic [IW-1:0] LAST_IDX = IW'(PAYLOAD);
    localparam logic [GW-1:0] GAP_LIM  = GW'(MAX_GAP);

    typedef enum logic {
        S_IDLE,
        S_RECV
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d, idx_inc;
    logic [GW-1:0]     gap_q, gap_d, gap_inc;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [FLIT_W-1:0] prev_q;
    logic [PW-1:0]     pop_q;
    logic [CNT_W-1:0]  pkt_q, flit_q, idle_q, errc_q, tog_q;
    logic              ready_w;
    logic              accept;

    function automatic logic [CNT_W-1:0] sat_add(
        input logic [CNT_W-1:0] a,
        input logic [CNT_W-1:0] b
    );
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    function automatic logic [PW-1:0] popcount(
        input logic [FLIT_W-1:0] v
    );
        logic [PW-1:0] n;
        n = '0;
        for (int i = 0; i < FLIT_W; i++) begin
            n = n + PW'(v[i]);
        end
        return n;
    endfunction

    assign accept  = link.flit_valid && ready_w;
    assign idx_inc = idx_q + IW'(1);
    assign gap_inc = gap_q + GW'(1);

    // Packet framing: index tracking, gap timeout, done/err pulse requests
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                gap_d = '0;
                if (accept) begin
                    if (idx_inc == LAST_IDX) begin
                        done_d = 1'b1;
                        idx_d  = '0;
                    end else begin
                        idx_d   = idx_inc;
                        state_d = S_RECV;
                    end
                end
            end
            S_RECV: begin
                if (accept) begin
                    gap_d = '0;
                    if (idx_inc == LAST_IDX) begin
                        done_d  = 1'b1;
                        idx_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_inc;
                    end
                end else if (gap_inc == GAP_LIM) begin
                    err_d   = 1'b1;
                    idx_d   = '0;
                    gap_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_inc;
                end
            end
        endcase
        if (clear) begin
            state_d = S_IDLE;
            idx_d   = '0;
            gap_d   = '0;
            done_d  = 1'b0;
            err_d   = 1'b0;
        end
    end

    // Framing state register and one-cycle result pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            gap_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Last accepted flit; survives clear so toggles stay continuous
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= '0;
        end else if (accept) begin
            prev_q <= link.flit_data;
        end
    end

    // Saturating statistics counters and the two-stage toggle pipeline
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            pkt_q  <= '0;
            flit_q <= '0;
            idle_q <= '0;
            errc_q <= '0;
            tog_q  <= '0;
            pop_q  <= '0;
        end else begin
            if (accept) begin
                flit_q <= sat_add(flit_q, CNT_W'(1));
            end else begin
                idle_q <= sat_add(idle_q, CNT_W'(1));
            end
            if (done_d) begin
                pkt_q <= sat_add(pkt_q, CNT_W'(1));
            end
            if (err_d) begin
                errc_q <= sat_add(errc_q, CNT_W'(1));
            end
            pop_q <= accept ? popcount(link.flit_data ^ prev_q) : '0;
            tog_q <= sat_add(tog_q, CNT_W'(pop_q));
        end
    end

`ifdef FLIT_READY_EN
    localparam int SW = $clog2(STALL_CYCLES + 2);

    logic [SW-1:0] stall_q, stall_d;

    // Stall countdown armed by each completed packet
    always_comb begin
        stall_d = stall_q;
        if (done_d) begin
            stall_d = SW'(STALL_CYCLES);
        end else if (stall_q != '0) begin
            stall_d = stall_q - SW'(1);
        end
    end

    // Stall counter register; clear leaves ready timing untouched
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign ready_w = (stall_q == '0);
`else
    assign ready_w = 1'b1;
`endif

    assign link.flit_ready = ready_w;
    assign pkt_done        = done_q;
    assign pkt_err         = err_q;
    assign pkt_count       = pkt_q;
    assign flit_count      = flit_q;
    assign idle_count      = idle_q;
    assign err_count       = errc_q;
    assign toggle_count    = tog_q;

endmodule

// File: tb/tb_flit_sink_monitor.sv
// Directed bench for flit_sink_monitor: vector table plus corner sequences.
// A second small-counter instance exercises counter saturation.
module tb_flit_sink_monitor;

    localparam logic [59:0] ONES = {60{1'b1}};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;
    logic clr1 = 1'b0;

    always #5 clk = ~clk;

    flit_sink_monitor_if #(.FLIT_W(60)) lk0 ();
    flit_sink_monitor_if #(.FLIT_W(60)) lk1 ();

    logic        done0, err0, done1, err1;
    logic [31:0] pkt0, flit0, idle0, errc0, tog0;
    logic [7:0]  pkt1, flit1, idle1, errc1, tog1;

    flit_sink_monitor #(
        .FLIT_W(60), .PAYLOAD(20), .MAX_GAP(16),
        .CNT_W(32), .STALL_CYCLES(2)
    ) dut (
        .clk(clk), .rst(rst), .link(lk0.slave), .clear(clr),
        .pkt_done(done0), .pkt_err(err0),
        .pkt_count(pkt0), .flit_count(flit0), .idle_count(idle0),
        .err_count(errc0), .toggle_count(tog0)
    );

    flit_sink_monitor #(
        .FLIT_W(60), .PAYLOAD(4), .MAX_GAP(16),
        .CNT_W(8), .STALL_CYCLES(2)
    ) dut_sat (
        .clk(clk), .rst(rst), .link(lk1.slave), .clear(clr1),
        .pkt_done(done1), .pkt_err(err1),
        .pkt_count(pkt1), .flit_count(flit1), .idle_count(idle1),
        .err_count(errc1), .toggle_count(tog1)
    );

    int checks = 0;
    int errors = 0;
    int n_done = 0;
    int n_err  = 0;

    typedef struct {
        logic        vld;
        logic [59:0] dat;
        logic        clr;
        logic [31:0] e_flit;
        logic [31:0] e_tog;
        logic [31:0] e_idle;
        logic [31:0] e_pkt;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (done0) n_done++;
        if (err0) n_err++;
    endtask

    task automatic idle(input int n);
        lk0.flit_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic send(input logic [59:0] d);
        bit ok;
        ok = 1'b0;
        lk0.flit_valid = 1'b1;
        lk0.flit_data  = d;
        for (int k = 0; k < 8 && !ok; k++) begin
            ok = lk0.flit_ready;
            step();
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got ready 0 expected 1");
        end
        lk0.flit_valid = 1'b0;
    endtask

    task automatic do_clear(input logic v, input logic [59:0] d);
        lk0.flit_valid = v;
        lk0.flit_data  = d;
        clr = 1'b1;
        step();
        clr = 1'b0;
        lk0.flit_valid = 1'b0;
    endtask

    initial begin
        int d0, e0;
        lk0.flit_valid = 1'b0;
        lk0.flit_data  = '0;
        lk1.flit_valid = 1'b0;
        lk1.flit_data  = '0;

        tbl[0] = '{1'b1, 60'hFFF_FFFF_FFFF_0000, 1'b0, 1, 0, 0, 0};
        tbl[1] = '{1'b0, 60'h0, 1'b0, 1, 44, 1, 0};
        tbl[2] = '{1'b1, 60'h0, 1'b0, 2, 44, 1, 0};
        tbl[3] = '{1'b1, ONES, 1'b0, 3, 88, 1, 0};
        tbl[4] = '{1'b0, 60'h0, 1'b0, 3, 148, 2, 0};
        tbl[5] = '{1'b1, 60'h1, 1'b1, 0, 0, 0, 0};
        tbl[6] = '{1'b1, 60'h3, 1'b0, 1, 0, 0, 0};
        tbl[7] = '{1'b0, 60'h0, 1'b0, 1, 1, 1, 0};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_ready", lk0.flit_ready, 1);
        check("rst_done", done0, 0);
        check("rst_err", err0, 0);
        check("rst_pkt", pkt0, 0);
        check("rst_flit", flit0, 0);
        check("rst_tog", tog0, 0);
        check("rst_errc", errc0, 0);

        for (int i = 0; i < 8; i++) begin
            lk0.flit_valid = tbl[i].vld;
            lk0.flit_data  = tbl[i].dat;
            clr = tbl[i].clr;
            step();
            check($sformatf("v%0d_flit", i), flit0, tbl[i].e_flit);
            check($sformatf("v%0d_tog", i), tog0, tbl[i].e_tog);
            check($sformatf("v%0d_idle", i), idle0, tbl[i].e_idle);
            check($sformatf("v%0d_pkt", i), pkt0, tbl[i].e_pkt);
        end
        clr = 1'b0;
        lk0.flit_valid = 1'b0;

        // ten packets, alternating data, 7 idle cycles between packets
        do_clear(1'b1, 60'h0);
        d0 = n_done;
        for (int p = 0; p < 10; p++) begin
            for (int f = 0; f < 20; f++) begin
                send((f % 2 == 0) ? ONES : 60'h0);
            end
            idle(7);
        end
        check("burst_pkt", pkt0, 10);
        check("burst_flit", flit0, 200);
        check("burst_tog", tog0, 12000);
        check("burst_idle", idle0, 70);
        check("burst_errc", errc0, 0);
        check("burst_pulses", n_done - d0, 10);

        // gap timeout after 5 flits
        do_clear(1'b0, 60'h0);
        e0 = n_err;
        for (int f = 0; f < 5; f++) send(60'h5);
        idle(15);
        check("gap15_errc", errc0, 0);
        idle(1);
        check("gap16_pulse", err0, 1);
        check("gap16_errc", errc0, 1);
        check("gap16_pkt", pkt0, 0);
        for (int f = 0; f < 20; f++) send(60'h5);
        idle(2);
        check("after_err_pkt", pkt0, 1);
        check("after_err_flit", flit0, 25);
        check("err_pulses", n_err - e0, 1);

        // clear in the middle of a packet
        idle(3);
        do_clear(1'b0, 60'h0);
        for (int f = 0; f < 8; f++) send(60'h5);
        do_clear(1'b1, 60'hFF);
        for (int f = 0; f < 20; f++) send(60'h0);
        idle(2);
        check("clr_pkt", pkt0, 1);
        check("clr_flit", flit0, 20);
        check("clr_tog", tog0, 8);
        check("clr_idle", idle0, 2);

        // accept on the cycle the timeout would fire wins
        idle(3);
        do_clear(1'b0, 60'h0);
        send(60'h0);
        idle(15);
        send(60'h0);
        idle(15);
        check("race_errc", errc0, 0);
        idle(1);
        check("race_late_errc", errc0, 1);

`ifdef FLIT_READY_EN
        // ready drops for two cycles after the final flit
        idle(3);
        do_clear(1'b0, 60'h0);
        for (int f = 0; f < 20; f++) send(60'h0);
        lk0.flit_valid = 1'b1;
        check("stall_c1", lk0.flit_ready, 0);
        step();
        check("stall_c2", lk0.flit_ready, 0);
        step();
        check("stall_c3", lk0.flit_ready, 1);
        step();
        lk0.flit_valid = 1'b0;
        check("stall_flit", flit0, 21);
        check("stall_idle", idle0, 2);
`endif

        // reset in the middle of a packet drops it silently
        idle(3);
        do_clear(1'b0, 60'h0);
        for (int f = 0; f < 3; f++) send(60'h0);
        e0 = n_err;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mrst_flit", flit0, 0);
        check("mrst_ready", lk0.flit_ready, 1);
        idle(20);
        check("mrst_errc", errc0, 0);
        check("mrst_pulses", n_err - e0, 0);

        // saturation on the 8-bit instance
        lk1.flit_valid = 1'b0;
        clr1 = 1'b1;
        step();
        clr1 = 1'b0;
        lk1.flit_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            lk1.flit_data = (k % 2 == 0) ? ONES : 60'h0;
            step();
        end
        check("sat_early_tog", tog1, 180);
        check("sat_early_flit", flit1, 4);
        check("sat_early_pkt", pkt1, 1);
        for (int k = 0; k < 600; k++) begin
            lk1.flit_data = (k % 2 == 0) ? ONES : 60'h0;
            step();
        end
        lk1.flit_valid = 1'b0;
        repeat (260) step();
        check("sat_tog", tog1, 255);
        check("sat_flit", flit1, 255);
        check("sat_idle", idle1, 255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
